inst_fetch_unit: RTL and testbench

//  Front end of the RV32 pipeline: producer side of the instDecoder input interface.

---
 rtl/inst_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// RV32 instruction fetch front end: PC generation, credit-limited memory requests,
// in-order response buffer and flush/drain. Define IFETCH_PERF_CNT_EN for fetch/drop counters.
module inst_fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            oMemReq,
  output logic [XLEN-1:0] oMemAddr,
  input  logic            iMemGnt,
  input  logic            iMemRvalid,
  input  logic [XLEN-1:0] iMemRdata,
  output logic [XLEN-1:0] oInst,
  output logic [XLEN-1:0] oCurPc,
  output logic            oInstDv,
  input  logic            iStall,
  input  logic            iFlushPipe,
  input  logic [XLEN-1:0] iNewPc,
  output logic [1:0]      fsm_state
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]     oFetchCnt,
  output logic [31:0]     oDropCnt
`endif
);

  // Handshakes: a request transfers when oMemReq && iMemGnt; an entry leaves the
  // buffer when oInstDv && !iStall. Responses carry no ready and arrive in request order.
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] fifo_inst [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
  logic [XLEN-1:0] tag_q     [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, tag_wr, tag_rd;
  logic [AW:0]     count, outstanding, drop_cnt;
  logic [AW:0]     out_flush, drain_left;
  logic            credit_ok, grant, accept, drop, pop;

  assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < {1'b0, FULL_C};
  assign oMemReq   = (state == RUN) && !iFlushPipe && credit_ok;
  assign oMemAddr  = pc;
  assign grant     = oMemReq && iMemGnt;
  assign accept    = iMemRvalid && (state == RUN) && !iFlushPipe;
  assign drop      = iMemRvalid && ((state == DRAIN) || ((state == RUN) && iFlushPipe));
  assign oInstDv   = (count != '0);
  assign pop       = oInstDv && !iStall && !iFlushPipe;
  assign oInst     = oInstDv ? fifo_inst[rd_ptr] : NOP;
  assign oCurPc    = oInstDv ? fifo_pc[rd_ptr] : last_pc;
  assign fsm_state = state;

  // Requests still owed by memory once a flush takes effect (flush-cycle response already gone).
  assign out_flush  = outstanding - (AW+1)'(iMemRvalid && (outstanding != '0));
  assign drain_left = drop_cnt - (AW+1)'(iMemRvalid && (drop_cnt != '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      last_pc     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (iFlushPipe && (out_flush != '0)) begin
            state    <= DRAIN;
            drop_cnt <= out_flush;
          end
        end
        DRAIN: begin
          drop_cnt <= drain_left;
          if (drain_left == '0) state <= RUN;
        end
        default: state <= IDLE;
      endcase

      if (iFlushPipe) begin
        pc          <= iNewPc & ~XLEN'(3);
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        tag_wr      <= '0;
        tag_rd      <= '0;
        count       <= '0;
        outstanding <= '0;
      end else begin
        if (grant) begin
          pc            <= pc + XLEN'(4);
          tag_q[tag_wr] <= pc;
          tag_wr        <= tag_wr + 1'b1;
        end
        if (accept) begin
          fifo_inst[wr_ptr] <= iMemRdata;
          fifo_pc[wr_ptr]   <= tag_q[tag_rd];
          wr_ptr            <= wr_ptr + 1'b1;
          tag_rd            <= tag_rd + 1'b1;
        end
        if (pop) begin
          rd_ptr  <= rd_ptr + 1'b1;
          last_pc <= fifo_pc[rd_ptr];
        end
        count       <= count + (AW+1)'(accept) - (AW+1)'(pop);
        outstanding <= outstanding + (AW+1)'(grant) - (AW+1)'(accept);
      end
    end
  end

  // The credit rule keeps both the buffer and the tag queue from overflowing.
  assert property (@(posedge clk) disable iff (!rst) !(accept && (count == FULL_C) && !pop));
  assert property (@(posedge clk) disable iff (!rst) !(accept && (outstanding == '0)));

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, discard_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      if (pop && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 32'd1;
      if (drop && (discard_cnt != '1)) discard_cnt <= discard_cnt + 32'd1;
    end
  end

  assign oFetchCnt = fetch_cnt;
  assign oDropCnt  = discard_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: in-order memory model, expected-PC scoreboard,
// reset/sequential/stall/flush/wrap scenarios, perf counters when IFETCH_PERF_CNT_EN is set.
module tb_inst_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'h5EED_0000;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        iMemGnt, iMemRvalid, iStall, iFlushPipe;
  logic [31:0] iMemRdata, iNewPc;
  logic        oMemReq, oInstDv;
  logic [31:0] oMemAddr, oInst, oCurPc;
  logic [1:0]  fsm_state;

  logic        w_gnt, w_req, w_dv;
  logic [31:0] w_addr, w_inst, w_pc;
  logic [1:0]  w_state;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] oFetchCnt, oDropCnt, w_fcnt, w_dcnt;
`endif

  inst_fetch_unit u_dut (
    .clk(clk), .rst(rst), .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemGnt(iMemGnt),
    .iMemRvalid(iMemRvalid), .iMemRdata(iMemRdata), .oInst(oInst), .oCurPc(oCurPc),
    .oInstDv(oInstDv), .iStall(iStall), .iFlushPipe(iFlushPipe), .iNewPc(iNewPc),
    .fsm_state(fsm_state)
`ifdef IFETCH_PERF_CNT_EN
    , .oFetchCnt(oFetchCnt), .oDropCnt(oDropCnt)
`endif
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .oMemReq(w_req), .oMemAddr(w_addr), .iMemGnt(w_gnt),
    .iMemRvalid(1'b0), .iMemRdata(32'h0), .oInst(w_inst), .oCurPc(w_pc),
    .oInstDv(w_dv), .iStall(1'b0), .iFlushPipe(1'b0), .iNewPc(32'h0),
    .fsm_state(w_state)
`ifdef IFETCH_PERF_CNT_EN
    , .oFetchCnt(w_fcnt), .oDropCnt(w_dcnt)
`endif
  );

  // scoreboard and memory model state
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_rdy[$];
  int          checks = 0, failures = 0;
  int          cyc, lat, pops, drops;
  logic        gnt_en;
  logic [31:0] model_pc, new_pc_v;
  logic        st_flush, st_grant, st_pop;
  logic [31:0] st_addr, st_pc;

  task automatic do_reset();
    rst = 1'b0;
    iMemGnt = 1'b0; iMemRvalid = 1'b0; iMemRdata = '0;
    iStall = 1'b0; iFlushPipe = 1'b0; iNewPc = '0;
    gnt_en = 1'b0; lat = 1; new_pc_v = '0;
    exp_q.delete(); pend_addr.delete(); pend_rdy.delete();
    cyc = 0; pops = 0; drops = 0; model_pc = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One cycle: drive inputs at negedge, sample #1 later, update model and scoreboard.
  // flush_mode: 0 none, 1 flush, 2 flush only when a response and a valid head coincide.
  task automatic step(input int flush_mode);
    int n_pend;
    iMemGnt = gnt_en;
    if (pend_addr.size() > 0 && pend_rdy[0] <= cyc) begin
      iMemRvalid = 1'b1; iMemRdata = pend_addr[0] ^ KEY;
    end else begin
      iMemRvalid = 1'b0; iMemRdata = $urandom;
    end
    iFlushPipe = (flush_mode == 1) || (flush_mode == 2 && iMemRvalid && oInstDv);
    iNewPc = new_pc_v;
    #1;
    st_flush = iFlushPipe; st_grant = 1'b0; st_pop = 1'b0;
    n_pend = pend_addr.size();
    if (iMemRvalid) begin
      void'(pend_addr.pop_front()); void'(pend_rdy.pop_front());
    end
    if (oMemReq && iMemGnt) begin
      checks++;
      if (oMemAddr !== model_pc)
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, oMemAddr, model_pc);
      if (oMemAddr !== model_pc) failures++;
      pend_addr.push_back(oMemAddr); pend_rdy.push_back(cyc + lat);
      st_grant = 1'b1; st_addr = oMemAddr;
      if (!iFlushPipe) begin
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
    end
    if (iFlushPipe) begin
      checks++;
      if (oMemReq !== 1'b0) begin
        failures++; $display("FAIL flush_req cyc=%0d got=%b exp=0", cyc, oMemReq);
      end
      drops += n_pend;
      exp_q.delete();
      model_pc = iNewPc & ~32'd3;
    end else if (oInstDv && !iStall) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out cyc=%0d pc=%h", cyc, oCurPc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks += 2;
        if (oCurPc !== e) begin
          failures++; $display("FAIL out_pc cyc=%0d got=%h exp=%h", cyc, oCurPc, e);
        end
        if (oInst !== (e ^ KEY)) begin
          failures++; $display("FAIL out_inst cyc=%0d got=%h exp=%h", cyc, oInst, e ^ KEY);
        end
      end
      pops++; st_pop = 1'b1; st_pc = oCurPc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Stop issuing and run until every expected entry has come out.
  task automatic run_until_empty(output logic ok);
    gnt_en = 1'b0;
    for (int i = 0; i < 40 && (exp_q.size() > 0 || pend_addr.size() > 0); i++) step(0);
    ok = (exp_q.size() == 0) && (pend_addr.size() == 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    iMemGnt = 1'b1; iMemRvalid = 1'b0; iMemRdata = '0;
    iStall = 1'b0; iFlushPipe = 1'b0; iNewPc = '0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (oMemReq !== 1'b0)  begin failures++; $display("FAIL rst_req got=%b exp=0", oMemReq); end
    if (oMemAddr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", oMemAddr); end
    if (oInstDv !== 1'b0)  begin failures++; $display("FAIL rst_dv got=%b exp=0", oInstDv); end
    if (oInst !== NOP)     begin failures++; $display("FAIL rst_inst got=%h exp=%h", oInst, NOP); end
    if (oCurPc !== 32'h0)  begin failures++; $display("FAIL rst_pc got=%h exp=0", oCurPc); end
    if (fsm_state !== S_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", fsm_state, S_IDLE); end
  endtask

  task automatic test_sequential();
    logic ok;
    do_reset();
    gnt_en = 1'b1; lat = 1;
    step(0);
    checks++;
    if (fsm_state !== S_RUN) begin failures++; $display("FAIL seq_run got=%0d exp=%0d", fsm_state, S_RUN); end
    repeat (20) step(0);
    run_until_empty(ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL seq_drain left=%0d exp=0", exp_q.size()); end
    if (pops < 5) begin failures++; $display("FAIL seq_pops got=%0d exp>=5", pops); end
  endtask

  task automatic test_stall();
    logic ok;
    do_reset();
    gnt_en = 1'b1; lat = 1; iStall = 1'b1;
    repeat (6) step(0);
    checks += 4;
    if (oMemReq !== 1'b0) begin failures++; $display("FAIL stall_req got=%b exp=0", oMemReq); end
    if (oInstDv !== 1'b1) begin failures++; $display("FAIL stall_dv got=%b exp=1", oInstDv); end
    if (oCurPc !== 32'h0) begin failures++; $display("FAIL stall_pc got=%h exp=0", oCurPc); end
    if (oInst !== KEY)    begin failures++; $display("FAIL stall_inst got=%h exp=%h", oInst, KEY); end
    iStall = 1'b0;
    repeat (6) step(0);
    run_until_empty(ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL stall_drain left=%0d exp=0", exp_q.size()); end
    if (pops < 3) begin failures++; $display("FAIL stall_pops got=%0d exp>=3", pops); end
  endtask

  task automatic test_flush_drain();
    logic ok;
    bit   seen;
    do_reset();
    gnt_en = 1'b1; lat = 4; new_pc_v = 32'h0000_0103;
    for (int i = 0; i < 10 && pend_addr.size() < 2; i++) step(0);
    checks++;
    if (pend_addr.size() != 2) begin failures++; $display("FAIL fd_outstanding got=%0d exp=2", pend_addr.size()); end
    step(1);
    checks += 3;
    if (fsm_state !== S_DRAIN) begin failures++; $display("FAIL fd_state got=%0d exp=%0d", fsm_state, S_DRAIN); end
    if (oMemReq !== 1'b0) begin failures++; $display("FAIL fd_req got=%b exp=0", oMemReq); end
    if (oInstDv !== 1'b0) begin failures++; $display("FAIL fd_dv got=%b exp=0", oInstDv); end
    seen = 0;
    for (int i = 0; i < 15 && !seen; i++) begin
      step(0);
      if (st_grant) begin
        seen = 1; checks++;
        if (st_addr !== 32'h100) begin failures++; $display("FAIL fd_new_addr got=%h exp=100", st_addr); end
      end
    end
    if (!seen) begin checks++; failures++; $display("FAIL fd_grant_timeout got=none exp=grant"); end
    seen = 0;
    for (int i = 0; i < 15 && !seen; i++) begin
      step(0);
      if (st_pop) begin
        seen = 1; checks++;
        if (st_pc !== 32'h100) begin failures++; $display("FAIL fd_new_pc got=%h exp=100", st_pc); end
      end
    end
    if (!seen) begin checks++; failures++; $display("FAIL fd_pop_timeout got=none exp=pop"); end
    run_until_empty(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fd_drain left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_flush_same_cycle();
    logic ok;
    bit   seen;
    do_reset();
    gnt_en = 1'b1; lat = 1; new_pc_v = 32'h0000_0200;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(2);
      seen = st_flush;
    end
    checks += 3;
    if (!seen) begin failures++; $display("FAIL fs_timeout got=none exp=flush"); end
    if (oInstDv !== 1'b0) begin failures++; $display("FAIL fs_dv got=%b exp=0", oInstDv); end
    if (fsm_state !== S_RUN) begin failures++; $display("FAIL fs_state got=%0d exp=%0d", fsm_state, S_RUN); end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(0);
      if (st_pop) begin
        seen = 1; checks++;
        if (st_pc !== 32'h200) begin failures++; $display("FAIL fs_new_pc got=%h exp=200", st_pc); end
      end
    end
    if (!seen) begin checks++; failures++; $display("FAIL fs_pop_timeout got=none exp=pop"); end
    run_until_empty(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fs_drain left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (w_req && w_gnt) addrs.push_back(w_addr);
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (addrs.size() < 2) begin
      failures++; $display("FAIL wrap_count got=%0d exp>=2", addrs.size());
    end else begin
      checks += 2;
      if (addrs[0] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first got=%h exp=fffffffc", addrs[0]); end
      if (addrs[1] !== 32'h0) begin failures++; $display("FAIL wrap_second got=%h exp=0", addrs[1]); end
    end
  endtask

`ifdef IFETCH_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    gnt_en = 1'b1; lat = 1; new_pc_v = 32'h0000_0103;
    for (int i = 0; i < 60 && pops < 10; i++) step(0);
    gnt_en = 1'b0;
    for (int i = 0; i < 10 && pend_addr.size() > 0; i++) step(0);
    iStall = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(0);
    iStall = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(0);
    gnt_en = 1'b1; lat = 4; iStall = 1'b1;
    for (int i = 0; i < 10 && pend_addr.size() < 2; i++) step(0);
    iStall = 1'b0;
    step(1);
    gnt_en = 1'b0;
    for (int i = 0; i < 15 && (pend_addr.size() > 0 || fsm_state != S_RUN); i++) step(0);
    checks += 2;
    if (oFetchCnt !== 32'(pops)) begin failures++; $display("FAIL perf_fetch got=%0d exp=%0d", oFetchCnt, pops); end
    if (oDropCnt !== 32'(drops)) begin failures++; $display("FAIL perf_drop got=%0d exp=%0d", oDropCnt, drops); end
  endtask
`endif

  initial begin
    w_gnt = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_flush_drain();
    test_flush_same_cycle();
    test_wrap();
`ifdef IFETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
